// File: rtl/fifo_pkg.sv
// Shared default dimensions for the synchronous FIFO and its storage.
package fifo_pkg;
  localparam int FIFO_DATA_W = 16;
  localparam int FIFO_ADDR_W = 4;
endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, single clock.
module sdp_ram
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [0:(2**ADDR_W)-1];
  logic [DATA_W-1:0] rdata_r;

  // Storage array write port, deliberately without reset so it maps to block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read-first output register: holds its value unless a read is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_r <= {DATA_W{1'b0}};
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointer, occupancy, status-flag and sticky error logic
// around an sdp_ram with a one-cycle registered read.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W   = FIFO_DATA_W,
  parameter int ADDR_W   = FIFO_ADDR_W,
  parameter int AF_LEVEL = (2**ADDR_W) - 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(2**ADDR_W);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] ZERO_C  = {(ADDR_W+1){1'b0}};

  logic [ADDR_W:0] wr_ptr_r;
  logic [ADDR_W:0] rd_ptr_r;
  logic [ADDR_W:0] count_r;
  logic [ADDR_W:0] count_nxt_s;
  logic            wr_acc_s;
  logic            rd_acc_s;
  logic            rd_valid_r;
  logic            full_r;
  logic            empty_r;
  logic            almost_full_r;
  logic            overflow_r;
  logic            underflow_r;

  // Accept decisions and next occupancy; a flush suppresses both ports.
  always_comb begin
    rd_acc_s    = 1'b0;
    wr_acc_s    = 1'b0;
    count_nxt_s = count_r;
    if (clr) begin
      count_nxt_s = ZERO_C;
    end else begin
      rd_acc_s = rd_en & ~empty_r;
      // A full FIFO still takes a write when a read frees a slot at the same edge.
      wr_acc_s = wr_en & (~full_r | rd_acc_s);
      if (wr_acc_s && !rd_acc_s) begin
        count_nxt_s = count_r + ONE_C;
      end else if (rd_acc_s && !wr_acc_s) begin
        count_nxt_s = count_r - ONE_C;
      end else begin
        count_nxt_s = count_r;
      end
    end
  end

  // Pointers, occupancy, flags and sticky errors; flags track next-state count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r      <= ZERO_C;
      rd_ptr_r      <= ZERO_C;
      count_r       <= ZERO_C;
      rd_valid_r    <= 1'b0;
      empty_r       <= 1'b1;
      full_r        <= 1'b0;
      almost_full_r <= 1'b0;
      overflow_r    <= 1'b0;
      underflow_r   <= 1'b0;
    end else if (clr) begin
      wr_ptr_r      <= ZERO_C;
      rd_ptr_r      <= ZERO_C;
      count_r       <= ZERO_C;
      rd_valid_r    <= 1'b0;
      empty_r       <= 1'b1;
      full_r        <= 1'b0;
      almost_full_r <= 1'b0;
      overflow_r    <= 1'b0;
      underflow_r   <= 1'b0;
    end else begin
      wr_ptr_r      <= wr_acc_s ? wr_ptr_r + ONE_C : wr_ptr_r;
      rd_ptr_r      <= rd_acc_s ? rd_ptr_r + ONE_C : rd_ptr_r;
      count_r       <= count_nxt_s;
      rd_valid_r    <= rd_acc_s;
      empty_r       <= (count_nxt_s == ZERO_C);
      full_r        <= (count_nxt_s == DEPTH_C);
      almost_full_r <= (count_nxt_s >= AF_C);
      overflow_r    <= overflow_r | (wr_en & ~wr_acc_s);
      underflow_r   <= underflow_r | (rd_en & ~rd_acc_s);
    end
  end

  sdp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc_s),
    .waddr (wr_ptr_r[ADDR_W-1:0]),
    .wdata (wr_data),
    .re    (rd_acc_s),
    .raddr (rd_ptr_r[ADDR_W-1:0]),
    .rdata (rd_data)
  );

  assign rd_valid    = rd_valid_r;
  assign full        = full_r;
  assign empty       = empty_r;
  assign almost_full = almost_full_r;
  assign count       = count_r;
  assign overflow    = overflow_r;
  assign underflow   = underflow_r;

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: a queue-based reference model predicts
// status and read data; a negedge monitor checks every presented read word.
module tb_sync_fifo;
  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AFL   = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] mq[$];
  logic [DW-1:0] exp_q[$];
  bit            m_ovf    = 1'b0;
  bit            m_unf    = 1'b0;
  bit            exp_rv   = 1'b0;
  logic [DW-1:0] held_exp = 16'h0000;

  sync_fifo #(.DATA_W(DW), .ADDR_W(AW), .AF_LEVEL(AFL)) dut (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .full(full),
    .empty(empty), .almost_full(almost_full), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_status();
    chk("count", 32'(count), 32'(mq.size()));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("full", 32'(full), 32'(mq.size() == DEPTH));
    chk("almost_full", 32'(almost_full), 32'(mq.size() >= AFL));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
  endtask

  // One clock of stimulus; the model applies the FIFO rules at the edge.
  task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
    bit rok;
    bit wok;
    wr_en = w; wr_data = d; rd_en = r; clr = c;
    @(posedge clk);
    exp_rv = 1'b0;
    if (c) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      rok = r && (mq.size() > 0);
      wok = w && ((mq.size() < DEPTH) || rok);
      if (rok) begin
        exp_q.push_back(mq.pop_front());
        exp_rv = 1'b1;
      end
      if (wok) mq.push_back(d);
      if (w && !wok) m_ovf = 1'b1;
      if (r && !rok) m_unf = 1'b1;
    end
    #1;
    wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
    check_status();
  endtask

  task automatic check_reset_values();
    chk("rst_rd_data", 32'(rd_data), 32'h0);
    chk("rst_rd_valid", 32'(rd_valid), 32'h0);
    check_status();
  endtask

  // Asynchronous reset asserted between edges; outputs must respond at once.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    mq.delete(); exp_q.delete();
    m_ovf = 1'b0; m_unf = 1'b0; exp_rv = 1'b0; held_exp = 16'h0000;
    #1;
    check_reset_values();
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  // Monitor: every presented read word must match the oldest expected word.
  always @(negedge clk) begin
    chk("rd_valid", 32'(rd_valid), 32'(exp_rv));
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_unexpected: got %0h expected no read at %0t", rd_data, $time);
      end else begin
        held_exp = exp_q.pop_front();
        chk("rd_data", 32'(rd_data), 32'(held_exp));
      end
    end else begin
      chk("rd_hold", 32'(rd_data), 32'(held_exp));
    end
  end

  initial begin
    rst = 1'b1; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = 16'h0000;
    #1;
    check_reset_values();
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Fill to full, then one dropped write.
    for (int i = 1; i <= 16; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
    step(1'b1, 16'hFFFF, 1'b0, 1'b0);
    // Drain in order, then a read on empty.
    for (int i = 0; i < 16; i++) step(1'b0, 16'h0000, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b1);

    // Simultaneous write and read on empty: write kept, read rejected.
    step(1'b1, 16'h5A5A, 1'b1, 1'b0);
    step(1'b1, 16'h0101, 1'b0, 1'b0);
    step(1'b1, 16'h0102, 1'b0, 1'b0);
    // Steady-count streaming across pointer wrap.
    for (int i = 0; i < 40; i++) step(1'b1, 16'(16'h2000 + i), 1'b1, 1'b0);

    // Fill, then write+read while full.
    for (int i = 0; i < 13; i++) step(1'b1, 16'(16'h3000 + i), 1'b0, 1'b0);
    step(1'b1, 16'hABCD, 1'b1, 1'b0);
    step(1'b1, 16'hDEAD, 1'b0, 1'b0);
    // Drain to five, then flush with a concurrent write.
    for (int i = 0; i < 11; i++) step(1'b0, 16'h0000, 1'b1, 1'b0);
    step(1'b1, 16'hBEEF, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b1, 1'b0);

    // Randomized traffic alternating fill-biased and drain-biased phases.
    for (int i = 0; i < 400; i++) begin
      bit ph;
      ph = ((i / 40) % 2) == 0;
      step($urandom_range(0, 99) < (ph ? 75 : 30), 16'($urandom),
           $urandom_range(0, 99) < (ph ? 30 : 75), $urandom_range(0, 79) == 0);
    end

    // Reset in the middle of traffic.
    for (int i = 0; i < 6; i++) step(1'b1, 16'(16'h4000 + i), i > 2, 1'b0);
    do_reset();
    step(1'b1, 16'h7777, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);

    for (int i = 0; i < 20; i++) begin
      if (mq.size() > 0) step(1'b0, 16'h0000, 1'b1, 1'b0);
    end
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 16, data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 4, storage address width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL have parameter AF_LEVEL, default 2**ADDR_W - 2, almost_full threshold; legal range 1..DEPTH.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port clr  input  1  synchronous flush, active-high.
REQ-007 SHALL have port wr_en  input  1  write request.
REQ-008 SHALL have port wr_data  input  DATA_W  write word.
REQ-009 SHALL have port rd_en  input  1  read request.
REQ-010 SHALL have port rd_data  output  DATA_W  read word, registered.
REQ-011 SHALL have port rd_valid  output  1  rd_data updated this cycle.
REQ-012 SHALL have port full, empty, almost_full  output  1 each  status flags, registered.
REQ-013 SHALL have port count  output  ADDR_W+1  stored entries, 0..DEPTH.
REQ-014 SHALL have port overflow, underflow  output  1 each  sticky error flags.

Function
REQ-015 SHALL accept a write when wr_en=1 and (full=0 or rd_en=1 with the read accepted), storing wr_data at wr_ptr and advancing wr_ptr by 1.
REQ-016 SHALL accept a read when rd_en=1 and empty=0, advancing rd_ptr by 1.
REQ-017 SHALL present the word read at edge N on rd_data with rd_valid=1 after edge N (1-cycle latency, BRAM-style registered output).
REQ-018 SHALL hold rd_data unchanged and drive rd_valid=0 in any cycle with no accepted read.
REQ-019 SHALL use ADDR_W+1-bit pointers wrapping modulo 2*DEPTH; low ADDR_W bits address storage.
REQ-020 SHALL update count +1 on write-only, -1 on read-only, unchanged on both or neither.
REQ-021 SHALL drive empty=(count==0), full=(count==DEPTH), almost_full=(count>=AF_LEVEL), all from next-state count, so flags are valid the cycle after the causing edge.
REQ-022 Full plus wr_en plus rd_en: both accepted, count stays DEPTH, no overflow.
REQ-023 Empty plus wr_en plus rd_en: write accepted, read rejected, underflow set, rd_valid=0.
REQ-024 wr_en while full with no accepted read: write dropped, storage unchanged, overflow set.
REQ-025 rd_en while empty: read dropped, underflow set.
REQ-026 overflow and underflow SHALL stay 1 until rst or clr.
REQ-027 clr=1 SHALL override wr_en and rd_en: pointers and count go to 0, flags reach their reset values, rd_valid=0, rd_data held.
REQ-028 Read-after-write to the same entry SHALL return the new word only when the write edge precedes the read edge; no same-cycle bypass is needed because an empty FIFO rejects reads.

Reset
REQ-029 rst=1 SHALL immediately force wr_ptr=0, rd_ptr=0, count=0, rd_data=0, rd_valid=0, empty=1, full=0, almost_full=0, overflow=0, underflow=0.
REQ-030 Storage contents SHALL NOT be reset; reset mid-operation discards all entries.
REQ-031 The first accepted write SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-032 A shared package fifo_pkg SHALL hold default constants FIFO_DATA_W=16 and FIFO_ADDR_W=4; no typedefs.
REQ-033 Storage SHALL be one sub-module, sdp_ram: simple dual-port, one write port, one registered read port, single clk, parameters DATA_W and ADDR_W, inferable as block RAM.
REQ-034 Pointer, count, flag and error logic SHALL live in sync_fifo.

Verification (DATA_W=16, ADDR_W=4, AF_LEVEL=14)
REQ-035 Write 0x0001..0x0010 (16 words) -> full=1, count=16, almost_full asserted once count reaches 14; 17th write 0xFFFF -> overflow=1, contents unchanged.
REQ-036 Full FIFO, read 16 -> rd_data 0x0001..0x0010 in order, one cycle after each rd_en; then empty=1; one more rd_en -> underflow=1, rd_valid=0.
REQ-037 Stream 40 writes with simultaneous reads at steady count 3 -> pointer wrap, in-order data, count constant at 3.
REQ-038 Full FIFO, wr_en=rd_en=1 for one cycle -> count=16, oldest word out, new word stored, overflow=0.
REQ-039 Count 5, assert clr with wr_en=1 -> count=0, empty=1, sticky flags cleared, write dropped; assert rst mid-stream -> all outputs at reset values with no clock edge.
